// File: rtl/move_sequencer.sv
// Move sequencer: queues {steps, dir} commands and walks each one through
// direction setup, step counting from an external step engine, and a settle dwell.
module move_sequencer #(
  parameter int SIZE      = 32,
  parameter int DEPTH     = 4,
  parameter int DIR_SETUP = 25,
  parameter int DWELL     = 250
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [SIZE-1:0]          cmd_steps_i,
  input  logic                     cmd_dir_i,
  input  logic                     abort_i,
  input  logic                     step_i,
  output logic                     enable_o,
  output logic [SIZE-1:0]          steps_o,
  output logic                     dir_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (DIR_SETUP > DWELL) ? DIR_SETUP : DWELL;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETUP_LAST = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_DWELL} state_e;

  typedef struct packed {
    logic [SIZE-1:0] steps;
    logic            dir;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            push, pop;

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic [SIZE-1:0] cnt_q;
  logic [2:0]      sync_q;
  logic            step_edge;
  logic            enable_q, dir_q, done_q, aborted_q;
  logic [SIZE-1:0] steps_q;

  assign cmd_ready_o = (level_q < LW'(DEPTH)) && !abort_i && !reset_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == ST_IDLE) && (level_q != '0) && !abort_i;
  assign head        = mem_q[rd_ptr_q];
  // sync_q[1:0] is the synchronizer; sync_q[2] only remembers the previous level.
  assign step_edge   = sync_q[1] && !sync_q[2];

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // NOTE: the storage array has no reset; level_q alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_steps_i, cmd_dir_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      sync_q    <= '0;
      enable_q  <= 1'b0;
      steps_q   <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], step_i};
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_i) begin
        // Abort beats a completing edge in the same cycle, so done_q stays low.
        state_q   <= ST_IDLE;
        enable_q  <= 1'b0;
        cnt_q     <= '0;
        timer_q   <= '0;
        aborted_q <= (state_q != ST_IDLE) || (level_q != '0);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pop) begin
              steps_q <= head.steps;
              dir_q   <= head.dir;
              timer_q <= '0;
              if (head.steps != '0) state_q <= ST_SETUP;
              else                  done_q  <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (timer_q == SETUP_LAST) begin
              state_q  <= ST_RUN;
              enable_q <= 1'b1;
              timer_q  <= '0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          ST_RUN: begin
            if (step_edge) begin
              if (cnt_q + SIZE'(1) == steps_q) begin
                cnt_q    <= '0;
                enable_q <= 1'b0;
                done_q   <= 1'b1;
                timer_q  <= '0;
                state_q  <= ST_DWELL;
              end else begin
                cnt_q <= cnt_q + SIZE'(1);
              end
            end
          end
          ST_DWELL: begin
            if (timer_q == DWELL_LAST) begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign enable_o  = enable_q;
  assign steps_o   = steps_q;
  assign dir_o     = dir_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;
  assign level_o   = level_q;
  assign busy_o    = (state_q != ST_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_move_sequencer.sv
// Directed/randomized bench for move_sequencer; expectations come from timing
// rules (setup, 3-cycle edge latency, dwell) and a queue of expected moves.
module tb_move_sequencer;

  localparam int SIZE      = 32;
  localparam int DEPTH     = 4;
  localparam int DIR_SETUP = 25;
  localparam int DWELL     = 250;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic            clk;
  logic            reset_i;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [SIZE-1:0] cmd_steps_i;
  logic            cmd_dir_i;
  logic            abort_i;
  logic            step_i;
  logic            enable_o;
  logic [SIZE-1:0] steps_o;
  logic            dir_o;
  logic            busy_o;
  logic            done_o;
  logic            aborted_o;
  logic [LW-1:0]   level_o;

  move_sequencer #(
    .SIZE(SIZE), .DEPTH(DEPTH), .DIR_SETUP(DIR_SETUP), .DWELL(DWELL)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_steps_i(cmd_steps_i), .cmd_dir_i(cmd_dir_i), .abort_i(abort_i), .step_i(step_i),
    .enable_o(enable_o), .steps_o(steps_o), .dir_o(dir_o), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o), .level_o(level_o)
  );

  typedef struct {
    int steps;
    bit dir;
  } mv_t;

  mv_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc_n = 0;
  int  done_cnt = 0, abort_cnt = 0, en_rise_cnt = 0;
  int  last_done_cyc = -1;
  logic en_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc_n;
    end
    if (aborted_o === 1'b1) abort_cnt++;
    if (enable_o === 1'b1 && en_prev !== 1'b1) en_rise_cnt++;
    en_prev = enable_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input int steps, input bit dir);
    cmd_valid_i = 1'b1;
    cmd_steps_i = SIZE'(steps);
    cmd_dir_i   = dir;
    tick(1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic glitch(input int n);
    for (int i = 0; i < n; i++) begin
      step_i = 1'b1;
      tick(1);
      step_i = 1'b0;
      tick(2);
    end
  endtask

  task automatic wait_enable(input int exp_cyc, input string tag);
    int n;
    n = 0;
    while (enable_o !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    check(tag, cyc_n, exp_cyc);
  endtask

  task automatic wait_idle(input int exp_cyc, input string tag);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 2000) begin
      tick(1);
      n++;
    end
    check(tag, cyc_n, exp_cyc);
  endtask

  // Drives exactly m.steps step pulses while RUN is active; the last counted
  // edge must produce done_o exactly three cycles after step_i rose.
  task automatic run_move(input mv_t m, input string tag);
    int d0, r, n;
    d0 = done_cnt;
    r  = cyc_n;
    check({tag, "_steps_o"}, steps_o, m.steps);
    check({tag, "_dir_o"}, dir_o, m.dir);
    for (int i = 0; i < m.steps; i++) begin
      if (i == m.steps - 1) check({tag, "_no_early_done"}, done_cnt, d0);
      r = cyc_n;
      step_i = 1'b1;
      tick(1 + $urandom_range(1, 0));
      step_i = 1'b0;
      if (i < m.steps - 1) tick(2 + $urandom_range(3, 0));
    end
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      tick(1);
      n++;
    end
    check({tag, "_done_cyc"}, last_done_cyc, r + 3);
    check({tag, "_enable_off"}, enable_o, 0);
  endtask

  initial begin
    int  p, d0, a0, e0;
    mv_t m;

    reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_steps_i = '0; cmd_dir_i = 1'b0;
    abort_i = 1'b0; step_i = 1'b0;
    tick(2);
    check("rst_enable", enable_o, 0);
    check("rst_steps", steps_o, 0);
    check("rst_dir", dir_o, 0);
    check("rst_done", done_o, 0);
    check("rst_aborted", aborted_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_level", level_o, 0);
    check("rst_ready_low", cmd_ready_o, 0);
    reset_i = 1'b0;
    tick(1);
    check("idle_ready", cmd_ready_o, 1);

    // Single move {3, dir 1}, with step glitches while idle first.
    glitch(2);
    check("idle_glitch_busy", busy_o, 0);
    m.steps = 3; m.dir = 1'b1;
    push_cmd(m.steps, m.dir);
    p = cyc_n;
    check("one_level", level_o, 1);
    check("one_busy", busy_o, 1);
    wait_enable(p + 1 + DIR_SETUP, "one_enable_cyc");
    run_move(m, "one");
    wait_idle(last_done_cyc + DWELL, "one_busy_fall");
    check("one_dir_held", dir_o, 1);
    check("one_done_total", done_cnt, 1);

    // Zero-step move: done without ever enabling.
    d0 = done_cnt; e0 = en_rise_cnt;
    push_cmd(0, 1'b0);
    p = cyc_n;
    tick(1);
    check("zero_done", done_o, 1);
    check("zero_done_cyc", last_done_cyc, p + 1);
    check("zero_busy", busy_o, 0);
    tick(DIR_SETUP + 5);
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_no_enable", en_rise_cnt - e0, 0);

    // Random moves with glitches in SETUP and DWELL.
    for (int k = 0; k < 3; k++) begin
      m.steps = $urandom_range(4, 1);
      m.dir   = 1'($urandom_range(1, 0));
      push_cmd(m.steps, m.dir);
      p = cyc_n;
      glitch($urandom_range(3, 1));
      wait_enable(p + 1 + DIR_SETUP, "glitch_enable_cyc");
      run_move(m, "glitch");
      glitch($urandom_range(3, 1));
      wait_idle(last_done_cyc + DWELL, "glitch_busy_fall");
    end

    // Five moves back-to-back into a depth-4 queue.
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      m.steps = $urandom_range(3, 1);
      m.dir   = 1'($urandom_range(1, 0));
      exp_q.push_back(m);
      cmd_valid_i = 1'b1;
      cmd_steps_i = SIZE'(m.steps);
      cmd_dir_i   = m.dir;
      #1;
      check("b2b_ready", cmd_ready_o, 1);
      tick(1);
      if (i == 0) p = cyc_n;
      check("b2b_level", level_o, (i == 0) ? 1 : i);
    end
    cmd_steps_i = SIZE'(7);
    #1;
    check("b2b_full_ready", cmd_ready_o, 0);
    tick(1);
    cmd_valid_i = 1'b0;
    check("b2b_full_level", level_o, DEPTH);
    for (int j = 0; j < 5; j++) begin
      wait_enable((j == 0) ? p + 1 + DIR_SETUP : last_done_cyc + DWELL + 1 + DIR_SETUP,
                  "b2b_enable_cyc");
      check("b2b_level_run", level_o, 4 - j);
      m = exp_q.pop_front();
      run_move(m, "b2b");
    end
    wait_idle(last_done_cyc + DWELL, "b2b_busy_fall");
    check("b2b_done_count", done_cnt - d0, 5);

    // Abort during RUN with two moves still queued; push attempted meanwhile.
    push_cmd(4, 1'b1);
    p = cyc_n;
    push_cmd(2, 1'b0);
    push_cmd(3, 1'b1);
    wait_enable(p + 1 + DIR_SETUP, "abort_enable_cyc");
    step_i = 1'b1; tick(1); step_i = 1'b0; tick(4);
    d0 = done_cnt; a0 = abort_cnt; e0 = en_rise_cnt;
    abort_i = 1'b1; cmd_valid_i = 1'b1; cmd_steps_i = SIZE'(9);
    #1;
    check("abort_ready_low", cmd_ready_o, 0);
    tick(1);
    abort_i = 1'b0; cmd_valid_i = 1'b0;
    check("abort_enable", enable_o, 0);
    check("abort_level", level_o, 0);
    check("abort_pulse", aborted_o, 1);
    check("abort_busy", busy_o, 0);
    tick(1);
    check("abort_pulse_end", aborted_o, 0);
    glitch(3);
    tick(DIR_SETUP + 10);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_one_pulse", abort_cnt - a0, 1);
    check("abort_no_restart", en_rise_cnt - e0, 0);
    a0 = abort_cnt;
    abort_i = 1'b1; tick(1); abort_i = 1'b0; tick(2);
    check("abort_idle_no_pulse", abort_cnt - a0, 0);

    // Abort arriving in the same cycle as the completing edge.
    push_cmd(1, 1'b0);
    p = cyc_n;
    wait_enable(p + 1 + DIR_SETUP, "race_enable_cyc");
    d0 = done_cnt; a0 = abort_cnt;
    step_i = 1'b1;
    tick(2);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0; step_i = 1'b0;
    check("race_no_done", done_o, 0);
    check("race_aborted", aborted_o, 1);
    check("race_enable", enable_o, 0);
    tick(3);
    check("race_done_count", done_cnt - d0, 0);
    check("race_abort_count", abort_cnt - a0, 1);

    // Reset in the middle of RUN with a move queued behind it.
    push_cmd(5, 1'b1);
    p = cyc_n;
    push_cmd(2, 1'b0);
    wait_enable(p + 1 + DIR_SETUP, "rstrun_enable_cyc");
    step_i = 1'b1; tick(1); step_i = 1'b0; tick(4);
    d0 = done_cnt; a0 = abort_cnt; e0 = en_rise_cnt;
    reset_i = 1'b1;
    #1;
    check("rstrun_ready_low", cmd_ready_o, 0);
    tick(1);
    check("rstrun_enable", enable_o, 0);
    check("rstrun_steps", steps_o, 0);
    check("rstrun_dir", dir_o, 0);
    check("rstrun_busy", busy_o, 0);
    check("rstrun_level", level_o, 0);
    check("rstrun_done", done_o, 0);
    check("rstrun_aborted", aborted_o, 0);
    tick(1);
    reset_i = 1'b0;
    tick(DIR_SETUP + 10);
    check("rstrun_no_done", done_cnt - d0, 0);
    check("rstrun_no_abort", abort_cnt - a0, 0);
    check("rstrun_queue_gone", en_rise_cnt - e0, 0);

    // Normal operation after reset.
    m.steps = $urandom_range(4, 1);
    m.dir   = 1'($urandom_range(1, 0));
    push_cmd(m.steps, m.dir);
    p = cyc_n;
    wait_enable(p + 1 + DIR_SETUP, "post_enable_cyc");
    run_move(m, "post");
    wait_idle(last_done_cyc + DWELL, "post_busy_fall");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
